// File: rtl/ram_access_pkg.sv
// ram_access_pkg: shared size/state encodings and the byte-count helper for ram_access
package ram_access_pkg;
    typedef enum logic [1:0] {SIZE_BYTE, SIZE_HALF, SIZE_WORD, SIZE_DWORD} size_e;
    typedef enum logic [1:0] {IDLE, XFER, RLAST, DONE} state_e;
    function automatic logic [3:0] bytes_for_size(input logic [1:0] s);
        return 4'd1 << s;
    endfunction
endpackage

// File: rtl/ram_byte_array.sv
// ram_byte_array: single-port byte RAM, registered read, no read on write cycles
// Ports: clk; address byte index; data_in write byte; write_enable; data_out registered read byte
module ram_byte_array #(
    parameter int ADDR_WIDTH = 10,
    parameter bit INIT_ZERO  = 1'b0
) (
    input  logic                  clk,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [7:0]            data_in,
    input  logic                  write_enable,
    output logic [7:0]            data_out
);
    if (INIT_ZERO) begin : g_zero
        logic [7:0] r_mem [2**ADDR_WIDTH] = '{default: 8'h00};
        always_ff @(posedge clk)
            if (write_enable) r_mem[address] <= data_in;
            else data_out <= r_mem[address];
    end else begin : g_raw
        logic [7:0] r_mem [2**ADDR_WIDTH];
        always_ff @(posedge clk)
            if (write_enable) r_mem[address] <= data_in;
            else data_out <= r_mem[address];
    end
endmodule

// File: rtl/ram_access.sv
// ram_access: byte-serial load/store sequencer over a byte-wide RAM, little-endian, optional sign extension
// Ports: clk; reset_n async active-low; start/address/size/is_signed/write_enable/data_in request;
//        data_out load result; busy while not IDLE; done one-cycle completion; error with done on illegal size
module ram_access import ram_access_pkg::*; #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter bit INIT_ZERO  = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [1:0]            size,
    input  logic                  is_signed,
    input  logic                  write_enable,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);
    state_e                r_state, w_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [1:0]            r_size;
    logic                  r_signed, r_we, r_err;
    logic [DATA_WIDTH-1:0] r_wdata, r_buf, r_data_out;
    logic [2:0]            r_cnt;
    logic [3:0]            w_nbytes;
    logic                  w_last, w_illegal, w_sign, w_ram_we;
    logic [ADDR_WIDTH-1:0] w_ram_addr;
    logic [7:0]            w_ram_din, w_ram_q;
    logic [DATA_WIDTH-1:0] w_full, w_lo_mask, w_result;
    logic [6:0]            w_nbits;

    assign w_nbytes   = bytes_for_size(r_size);
    assign w_nbits    = {w_nbytes, 3'b000};
    assign w_last     = {1'b0, r_cnt} == w_nbytes - 4'd1;
    assign w_illegal  = size == SIZE_DWORD && DATA_WIDTH < 64;
    assign w_ram_addr = r_addr + ADDR_WIDTH'(r_cnt);
    assign w_ram_we   = r_state == XFER && r_we;
    assign w_ram_din  = 8'(r_wdata >> {r_cnt, 3'b000});
    // The byte arriving now belongs to lane r_cnt-1; in RLAST of a dword r_cnt has wrapped to 0, and 0-1 is lane 7.
    assign w_full     = r_buf | (DATA_WIDTH'(w_ram_q) << {r_cnt - 3'd1, 3'b000});
    // A full-width shift yields zero, so the mask becomes all ones when N fills the bus.
    assign w_lo_mask  = (DATA_WIDTH'(1) << w_nbits) - DATA_WIDTH'(1);
    assign w_sign     = 1'(w_full >> (w_nbits - 7'd1));
    assign w_result   = (r_signed && w_sign) ? (w_full | ~w_lo_mask) : (w_full & w_lo_mask);
    assign busy       = r_state != IDLE;
    assign done       = r_state == DONE;
    assign error      = done && r_err;
    assign data_out   = r_data_out;

    ram_byte_array #(.ADDR_WIDTH(ADDR_WIDTH), .INIT_ZERO(INIT_ZERO)) u_ram (
        .clk          (clk),
        .address      (w_ram_addr),
        .data_in      (w_ram_din),
        .write_enable (w_ram_we),
        .data_out     (w_ram_q)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = start ? (w_illegal ? DONE : XFER) : IDLE;
            XFER:    w_next = w_last ? (r_we ? DONE : RLAST) : XFER;
            RLAST:   w_next = DONE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_size     <= '0;
            r_signed   <= 1'b0;
            r_we       <= 1'b0;
            r_err      <= 1'b0;
            r_wdata    <= '0;
            r_buf      <= '0;
            r_cnt      <= '0;
            r_data_out <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && start) begin
                r_addr   <= address;
                r_size   <= size;
                r_signed <= is_signed;
                r_we     <= write_enable;
                r_wdata  <= data_in;
                r_err    <= w_illegal;
                r_buf    <= '0;
                r_cnt    <= '0;
            end
            if (r_state == XFER) r_cnt <= r_cnt + 3'd1;
            if (r_state == XFER && !r_we && r_cnt != 3'd0) r_buf <= w_full;
            if (r_state == RLAST) r_data_out <= w_result;
        end
    end
endmodule

// File: doc/ram_access.md
Name: ram_access

Overview:
- Parametrised byte-organised on-chip RAM with a built-in load/store sequencer.
- Services CPU memory accesses of 1, 2, 4 or 8 bytes over a single byte-wide synchronous storage array, one byte per cycle.
- Accesses are little-endian; loads are optionally sign-extended.
- Sits between the core's load/store unit and the block RAM. Uses a start/busy/done handshake instead of raw per-byte strobes.

Parameters:
- ADDR_WIDTH, 10, byte address width. Storage depth is 2**ADDR_WIDTH bytes.
- DATA_WIDTH, 32, load/store data width. Legal values are 32 or 64.
- INIT_ZERO, 0, when 1 the storage array is zero-initialised at configuration. It is never cleared by reset.

Ports:
- clk  input  1  single clock, all logic on rising edge.
- reset_n  input  1  asynchronous active-low reset; resets control state only.
- start  input  1  request strobe; sampled only in IDLE.
- address  input  ADDR_WIDTH  byte address of the first (least significant) byte.
- size  input  2  log2 of the byte count: 0=byte, 1=half, 2=word, 3=dword.
- is_signed  input  1  load sign-extend enable.
- write_enable  input  1  1=store, 0=load.
- data_in  input  DATA_WIDTH  store data; low bytes are used.
- data_out  output  DATA_WIDTH  load result.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle completion pulse.
- error  output  1  valid with done; illegal size.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; busy=0, done=0, error=0, data_out=0; byte counter=0.
  - Storage contents are untouched.
- Request capture:
  - On a clock edge in IDLE with start=1, latch address, size, is_signed, write_enable and data_in.
  - N = 1<<size.
  - start is ignored outside IDLE; there is no queueing.
- Illegal size: size=3 with DATA_WIDTH=32 goes IDLE -> DONE with error=1. No storage access occurs and data_out is unchanged.
- States: IDLE, XFER, RLAST, DONE.
  - XFER, counter i = 0..N-1, one cycle each. The byte address is (addr+i) mod 2**ADDR_WIDTH, so accesses wrap at the top of memory.
    - Store: storage[addr+i] <= data_in byte i.
    - Load: issue a synchronous read of addr+i. The returned byte is written into result lane i on the following edge.
  - After XFER i=N-1: a store goes to DONE; a load goes to RLAST, which captures the final byte and then goes to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
    - data_out is updated on entry to DONE, for loads only, and holds until the next completed load.
- Load result assembly:
  - Lanes 0..N-1 come from memory.
  - Upper lanes are filled with bit 7 of lane N-1 if is_signed=1, otherwise 0.
  - With N = DATA_WIDTH/8, is_signed has no effect.
- Latency, from the start-sampling edge T:
  - Store of N bytes: done at cycle T+N+1.
  - Load of N bytes: done at cycle T+N+2.
  - Word load: done at T+6. Byte store: done at T+2.
- Alignment is not checked; misaligned accesses are legal and simply sequence bytes.
- Reset mid-operation:
  - Aborts immediately to IDLE with no done pulse.
  - Bytes already written by a partial store remain in storage.
  - data_out is cleared to 0.
- Storage is a single read-or-write port per cycle, written so the tools infer block RAM:
  - registered read;
  - on a write cycle, no read occurs.

Decomposition:
- Shared package ram_access_pkg:
  - size encodings SIZE_BYTE/HALF/WORD/DWORD;
  - state encodings IDLE/XFER/RLAST/DONE;
  - function bytes_for_size.
- One natural sub-module: ram_byte_array, a parametrised ADDR_WIDTH x 8 single-port synchronous RAM (address, data_in, data_out, write_enable, clk). The sequencer instantiates it.

Test Plan:
- Word store then load: store address=0x004, size=2, data_in=0x44_99_55_A0. Then load unsigned from 0x004 -> done at T+6, data_out=0x449955A0; bytes 0x004..0x007 = A0,55,99,44.
- Signed/unsigned byte and half loads, with memory as above:
  - byte at 0x005, signed -> 0x00000055;
  - byte at 0x007 after storing 0x80, signed -> 0xFFFFFF80, unsigned -> 0x00000080;
  - half at 0x006, signed -> 0xFFFF8099.
- Wrap-around: store word 0xDEADBEEF at 0x3FE, then load from 0x3FE -> 0xDEADBEEF. Bytes at 0x3FE, 0x3FF, 0x000, 0x001 = EF, BE, AD, DE.
- Handshake: assert start every cycle during a word load -> exactly one done pulse, busy high T+1..T+6, second request accepted only at the first edge after the return to IDLE.
- Illegal size with DATA_WIDTH=32: size=3 -> done and error at T+1, storage unchanged, data_out holds its previous value. With DATA_WIDTH=64, a dword store/load of 0x0123456789ABCDEF round-trips.
- Reset mid-store: drop reset_n after 2 XFER cycles of a word store of 0x11223344 to 0x010 (previously 0) -> no done pulse, busy=0 immediately, memory at 0x010..0x013 = 44,33,00,00.
